// File: rtl/ttt_pkg.sv
// ttt_pkg: shared definitions for the tic-tac-toe referee.
//   - 2-bit cell encodings (01 is treated as empty)
//   - result status codes driven on o_status
//   - referee FSM state codes
//   - the eight winning lines as 0-based cell index triples, in win_line bit order
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b10;
    localparam logic [1:0] CELL_O     = 2'b11;

    localparam logic [1:0] ST_PLAYING = 2'b00;
    localparam logic [1:0] ST_X_WON   = 2'b01;
    localparam logic [1:0] ST_O_WON   = 2'b10;
    localparam logic [1:0] ST_DRAW    = 2'b11;

    localparam logic [1:0] S_PLAYING  = 2'd0;
    localparam logic [1:0] S_EVAL     = 2'd1;
    localparam logic [1:0] S_OVER     = 2'd2;
    localparam logic [1:0] S_CLEAR    = 2'd3;

    // Rows, then columns, then diagonals (cell n of the board is index n-1).
    localparam int unsigned WIN_LINES [8][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    function automatic logic [1:0] cell_at(input logic [17:0] cells, input int unsigned idx);
        return cells[2*idx +: 2];
    endfunction

endpackage

// File: rtl/win_eval.sv
// win_eval: combinational board evaluator.
//   i_cells   [17:0] nine 2-bit cells, cell n at bits [2n-1:2n-2]
//   o_x_lines [7:0]  lines completely owned by X (win_line bit order)
//   o_o_lines [7:0]  lines completely owned by O
//   o_full           every cell holds X or O
module win_eval
    import ttt_pkg::*;
(
    input  logic [17:0] i_cells,
    output logic [7:0]  o_x_lines,
    output logic [7:0]  o_o_lines,
    output logic        o_full
);

    always_comb begin
        o_x_lines = '0;
        o_o_lines = '0;
        o_full    = 1'b1;
        for (int l = 0; l < 8; l++) begin
            o_x_lines[l] = (cell_at(i_cells, WIN_LINES[l][0]) == CELL_X) &&
                           (cell_at(i_cells, WIN_LINES[l][1]) == CELL_X) &&
                           (cell_at(i_cells, WIN_LINES[l][2]) == CELL_X);
            o_o_lines[l] = (cell_at(i_cells, WIN_LINES[l][0]) == CELL_O) &&
                           (cell_at(i_cells, WIN_LINES[l][1]) == CELL_O) &&
                           (cell_at(i_cells, WIN_LINES[l][2]) == CELL_O);
        end
        for (int i = 0; i < 9; i++) begin
            if (!((cell_at(i_cells, i) == CELL_X) || (cell_at(i_cells, i) == CELL_O)))
                o_full = 1'b0;
        end
    end

endmodule

// File: rtl/game_referee.sv
// game_referee: watches the tic-tac-toe board, evaluates each move for a win
// or draw, latches the result, keeps running scores and sequences new games.
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_cells [17:0]         board cells (see ttt_pkg encodings)
//   i_move_made            board wrote a cell on this edge
//   i_new_game             level new-game request (debounced button)
//   o_status [1:0]         00 playing, 01 X won, 10 O won, 11 draw
//   o_win_line [7:0]       one-hot (or multi-hot) winning line(s)
//   o_move_count [3:0]     accepted moves this game, 0..9
//   o_lock                 board must ignore buttons
//   o_clear_board          one-cycle pulse that clears the board
//   o_score_x/o/draw_count saturating tallies, cleared only by reset
//
// state     | meaning
// PLAYING   | waiting for a move or a new-game request
// EVAL      | cells hold the new move; judge win / draw / continue
// OVER      | result held, moves ignored
// CLEAR     | pulse clear_board, zero per-game state
module game_referee
    import ttt_pkg::*;
#(
    parameter int SCORE_W = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [17:0]        i_cells,
    input  logic               i_move_made,
    input  logic               i_new_game,
    output logic [1:0]         o_status,
    output logic [7:0]         o_win_line,
    output logic [3:0]         o_move_count,
    output logic               o_lock,
    output logic               o_clear_board,
    output logic [SCORE_W-1:0] o_score_x,
    output logic [SCORE_W-1:0] o_score_o,
    output logic [SCORE_W-1:0] o_draw_count
);

    logic [1:0]         r_state;
    logic [1:0]         r_status;
    logic [7:0]         r_win_line;
    logic [3:0]         r_move_count;
    logic [SCORE_W-1:0] r_score_x;
    logic [SCORE_W-1:0] r_score_o;
    logic [SCORE_W-1:0] r_draw_count;
    logic [17:0]        r_cells_prev;
    logic               r_last_is_o;
    logic               r_ng_armed;

    logic [7:0]         w_x_lines;
    logic [7:0]         w_o_lines;
    logic               w_full;
    logic               w_last_is_o;
    logic               w_go_clear;
    logic               w_any_win;
    logic               w_o_wins;

    win_eval u_win_eval (
        .i_cells   (i_cells),
        .o_x_lines (w_x_lines),
        .o_o_lines (w_o_lines),
        .o_full    (w_full)
    );

    // Owner of the most recently written cell, seen combinationally so the
    // write that lands on the move edge is already visible during EVAL.
    always_comb begin
        w_last_is_o = r_last_is_o;
        for (int i = 0; i < 9; i++) begin
            if ((i_cells[2*i +: 2] != r_cells_prev[2*i +: 2]) && i_cells[2*i+1])
                w_last_is_o = i_cells[2*i];
        end
    end

    // A held button must be released before it can trigger another clear.
    assign w_go_clear = i_new_game && r_ng_armed;
    assign w_any_win  = (|w_x_lines) || (|w_o_lines);
    // Both colours complete only on an illegal board: the last writer wins.
    assign w_o_wins   = (|w_o_lines) && (!(|w_x_lines) || w_last_is_o);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_PLAYING;
            r_status     <= ST_PLAYING;
            r_win_line   <= '0;
            r_move_count <= '0;
            r_score_x    <= '0;
            r_score_o    <= '0;
            r_draw_count <= '0;
            r_cells_prev <= {9{CELL_EMPTY}};
            r_last_is_o  <= 1'b0;
            r_ng_armed   <= 1'b0;
        end else begin
            r_cells_prev <= i_cells;
            r_last_is_o  <= w_last_is_o;
            if (!i_new_game)
                r_ng_armed <= 1'b1;

            case (r_state)
                S_PLAYING: begin
                    if (w_go_clear) begin
                        r_state    <= S_CLEAR;
                        r_ng_armed <= 1'b0;
                    end else if (i_move_made) begin
                        if (r_move_count != 4'd9)
                            r_move_count <= r_move_count + 4'd1;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_any_win) begin
                        r_status   <= w_o_wins ? ST_O_WON : ST_X_WON;
                        r_win_line <= w_o_wins ? w_o_lines : w_x_lines;
                        if (w_o_wins) begin
                            if (r_score_o != '1)
                                r_score_o <= r_score_o + SCORE_W'(1);
                        end else begin
                            if (r_score_x != '1)
                                r_score_x <= r_score_x + SCORE_W'(1);
                        end
                        r_state <= S_OVER;
                    end else if (w_full) begin
                        r_status <= ST_DRAW;
                        if (r_draw_count != '1)
                            r_draw_count <= r_draw_count + SCORE_W'(1);
                        r_state <= S_OVER;
                    end else begin
                        r_state <= S_PLAYING;
                    end
                end
                S_OVER: begin
                    if (w_go_clear) begin
                        r_state    <= S_CLEAR;
                        r_ng_armed <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_status     <= ST_PLAYING;
                    r_win_line   <= '0;
                    r_move_count <= '0;
                    r_state      <= S_PLAYING;
                end
                default: r_state <= S_PLAYING;
            endcase
        end
    end

    assign o_status      = r_status;
    assign o_win_line    = r_win_line;
    assign o_move_count  = r_move_count;
    assign o_lock        = (r_state != S_PLAYING);
    assign o_clear_board = (r_state == S_CLEAR);
    assign o_score_x     = r_score_x;
    assign o_score_o     = r_score_o;
    assign o_draw_count  = r_draw_count;

endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: drives two referees (SCORE_W 4 and 2) from one stimulus
// stream acting as the board, and compares against a board-level model.
module tb_game_referee;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [17:0] cells = '0;
    logic        move_made = 1'b0;
    logic        new_game = 1'b0;

    logic [1:0]  status, status2;
    logic [7:0]  win_line, win_line2;
    logic [3:0]  move_count, move_count2;
    logic        lock, lock2, clear_board, clear_board2;
    logic [3:0]  score_x, score_o, draw_count;
    logic [1:0]  score_x2, score_o2, draw_count2;

    int errors = 0;
    int checks = 0;

    // Model: b[i] is 0 empty, 1 X, 2 O.
    int         b [9];
    int         m_status, m_count, m_sx, m_so, m_dr;
    logic [7:0] m_line;
    bit         m_over;
    int         wl [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    always #5 clk = ~clk;

    game_referee #(.SCORE_W(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_cells(cells), .i_move_made(move_made),
        .i_new_game(new_game), .o_status(status), .o_win_line(win_line),
        .o_move_count(move_count), .o_lock(lock), .o_clear_board(clear_board),
        .o_score_x(score_x), .o_score_o(score_o), .o_draw_count(draw_count)
    );

    game_referee #(.SCORE_W(2)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_cells(cells), .i_move_made(move_made),
        .i_new_game(new_game), .o_status(status2), .o_win_line(win_line2),
        .o_move_count(move_count2), .o_lock(lock2), .o_clear_board(clear_board2),
        .o_score_x(score_x2), .o_score_o(score_o2), .o_draw_count(draw_count2)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [7:0] lines_of(input int p);
        logic [7:0] m;
        m = '0;
        for (int l = 0; l < 8; l++)
            m[l] = (b[wl[l][0]] == p) && (b[wl[l][1]] == p) && (b[wl[l][2]] == p);
        return m;
    endfunction

    task automatic model_new_game();
        for (int i = 0; i < 9; i++) b[i] = 0;
        m_status = 0; m_count = 0; m_line = '0; m_over = 1'b0;
    endtask

    task automatic model_move(input int p);
        logic [7:0] xm, om;
        int filled, w;
        filled = 0;
        if (m_count < 9) m_count++;
        xm = lines_of(1);
        om = lines_of(2);
        for (int i = 0; i < 9; i++) if (b[i] != 0) filled++;
        if (xm != 0 || om != 0) begin
            w = (xm != 0 && om != 0) ? p : ((xm != 0) ? 1 : 2);
            m_status = w;
            m_line = (w == 1) ? xm : om;
            if (w == 1) m_sx++; else m_so++;
            m_over = 1'b1;
        end else if (filled == 9) begin
            m_status = 3;
            m_dr++;
            m_over = 1'b1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; cells = '0; move_made = 1'b0; new_game = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_new_game();
        m_sx = 0; m_so = 0; m_dr = 0;
        @(negedge clk);
    endtask

    // Board writes cell c (0-based) for player p on the edge that samples move_made.
    task automatic do_move(input int c, input int p);
        logic [14:0] exp_v;
        logic [11:0] exp_s;
        logic [5:0]  exp_s2;
        @(negedge clk);
        move_made = 1'b1;
        @(posedge clk);
        #1;
        cells[2*c +: 2] = (p == 1) ? 2'b10 : 2'b11;
        move_made = 1'b0;
        b[c] = p;
        model_move(p);
        @(negedge clk);
        checks++;
        if (lock !== 1'b1) begin
            errors++;
            $display("FAIL lock_during_eval: got %b want 1", lock);
        end
        @(posedge clk);
        @(negedge clk);
        exp_v = {2'(m_status), m_line, 4'(m_count), m_over};
        checks++;
        if ({status, win_line, move_count, lock} !== exp_v) begin
            errors++;
            $display("FAIL move_result cell=%0d: got status/line/count/lock=%h want %h",
                     c, {status, win_line, move_count, lock}, exp_v);
        end
        checks++;
        if ({status2, win_line2, move_count2, lock2} !== exp_v) begin
            errors++;
            $display("FAIL move_result_w2 cell=%0d: got %h want %h",
                     c, {status2, win_line2, move_count2, lock2}, exp_v);
        end
        exp_s = {4'(sat(m_sx, 15)), 4'(sat(m_so, 15)), 4'(sat(m_dr, 15))};
        checks++;
        if ({score_x, score_o, draw_count} !== exp_s) begin
            errors++;
            $display("FAIL scores: got x/o/d=%h want %h", {score_x, score_o, draw_count}, exp_s);
        end
        exp_s2 = {2'(sat(m_sx, 3)), 2'(sat(m_so, 3)), 2'(sat(m_dr, 3))};
        checks++;
        if ({score_x2, score_o2, draw_count2} !== exp_s2) begin
            errors++;
            $display("FAIL scores_w2: got x/o/d=%h want %h", {score_x2, score_o2, draw_count2}, exp_s2);
        end
    endtask

    // Write a cell without a move strobe (a misbehaving board).
    task automatic silent_set(input int c, input int p);
        @(negedge clk);
        cells[2*c +: 2] = (p == 1) ? 2'b10 : 2'b11;
        b[c] = p;
    endtask

    task automatic press_new_game(input int hold);
        int pulses, pulses2, first;
        bit pend;
        pulses = 0; pulses2 = 0; first = -1; pend = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (pend) begin cells = '0; pend = 1'b0; end
            if (clear_board) begin pulses++; if (first < 0) first = i; pend = 1'b1; end
            if (clear_board2) pulses2++;
        end
        @(negedge clk);
        new_game = 1'b0;
        @(posedge clk);
        #1;
        if (pend) cells = '0;
        if (clear_board) pulses++;
        if (clear_board2) pulses2++;
        model_new_game();
        @(negedge clk);
        checks++;
        if (pulses != 1 || pulses2 != 1) begin
            errors++;
            $display("FAIL clear_pulses hold=%0d: got %0d/%0d want 1/1", hold, pulses, pulses2);
        end
        checks++;
        if (first != 0) begin
            errors++;
            $display("FAIL clear_latency: got cycle %0d want 0", first);
        end
        checks++;
        if ({status, win_line, move_count, lock, clear_board} !== 16'h0) begin
            errors++;
            $display("FAIL after_clear: got %h want 0", {status, win_line, move_count, lock, clear_board});
        end
        checks++;
        if ({score_x, score_o, draw_count} !== {4'(sat(m_sx, 15)), 4'(sat(m_so, 15)), 4'(sat(m_dr, 15))}) begin
            errors++;
            $display("FAIL scores_retained: got %h", {score_x, score_o, draw_count});
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({status, win_line, move_count, lock, clear_board, score_x, score_o, draw_count} !== 28'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0",
                     {status, win_line, move_count, lock, clear_board, score_x, score_o, draw_count});
        end
        checks++;
        if ({status2, win_line2, move_count2, lock2, clear_board2, score_x2, score_o2, draw_count2} !== 22'h0) begin
            errors++;
            $display("FAIL reset_state_w2: got %h want 0",
                     {status2, win_line2, move_count2, lock2, clear_board2, score_x2, score_o2, draw_count2});
        end
    endtask

    task automatic test_x_row();
        do_move(0, 1); do_move(3, 2); do_move(1, 1); do_move(4, 2); do_move(2, 1);
        checks++;
        if ({status, win_line, move_count, lock, score_x} !== {2'b01, 8'h01, 4'd5, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL x_row: got %h want %h", {status, win_line, move_count, lock, score_x},
                     {2'b01, 8'h01, 4'd5, 1'b1, 4'd1});
        end
    endtask

    task automatic test_over_ignore();
        @(negedge clk); move_made = 1'b1;
        @(negedge clk); move_made = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({status, win_line, move_count, lock, score_x} !== {2'b01, 8'h01, 4'd5, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL over_ignore: got %h", {status, win_line, move_count, lock, score_x});
        end
        press_new_game(10);
    endtask

    task automatic test_draw();
        do_move(0, 1); do_move(1, 2); do_move(2, 1); do_move(4, 2); do_move(3, 1);
        do_move(5, 2); do_move(7, 1); do_move(6, 2); do_move(8, 1);
        checks++;
        if ({status, win_line, move_count, draw_count} !== {2'b11, 8'h00, 4'd9, 4'd1}) begin
            errors++;
            $display("FAIL draw: got %h want %h", {status, win_line, move_count, draw_count},
                     {2'b11, 8'h00, 4'd9, 4'd1});
        end
        press_new_game(3);
    endtask

    task automatic test_ninth_move_win();
        do_move(0, 1); do_move(2, 2); do_move(1, 1); do_move(3, 2); do_move(4, 1);
        do_move(6, 2); do_move(5, 1); do_move(7, 2); do_move(8, 1);
        checks++;
        if ({status, win_line, draw_count, score_x} !== {2'b01, 8'h40, 4'd1, 4'd2}) begin
            errors++;
            $display("FAIL ninth_move_win: got %h want %h", {status, win_line, draw_count, score_x},
                     {2'b01, 8'h40, 4'd1, 4'd2});
        end
        press_new_game(1);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        move_made = 1'b1;
        @(posedge clk);
        #1;
        cells[2*4 +: 2] = 2'b10;
        b[4] = 1;
        model_move(1);
        @(posedge clk);
        @(negedge clk);
        move_made = 1'b0;
        @(negedge clk);
        checks++;
        if ({status, move_count, lock} !== {2'(m_status), 4'(m_count), m_over}) begin
            errors++;
            $display("FAIL back_to_back: got %h want %h", {status, move_count, lock},
                     {2'(m_status), 4'(m_count), m_over});
        end
        press_new_game(2);
    endtask

    task automatic test_illegal_both();
        silent_set(3, 2); silent_set(4, 2);
        silent_set(0, 1); silent_set(1, 1); silent_set(2, 1);
        do_move(5, 2);
        checks++;
        if ({status, win_line} !== {2'b10, 8'h02}) begin
            errors++;
            $display("FAIL illegal_both: got %h want %h", {status, win_line}, {2'b10, 8'h02});
        end
        press_new_game(2);
    endtask

    task automatic test_random_games();
        int empties[$];
        int p, c;
        for (int g = 0; g < 6; g++) begin
            p = 1;
            while (!m_over) begin
                if ($urandom_range(19) == 0) break;
                empties.delete();
                for (int i = 0; i < 9; i++) if (b[i] == 0) empties.push_back(i);
                c = empties[$urandom_range(empties.size() - 1)];
                do_move(c, p);
                p = 3 - p;
            end
            press_new_game(1 + int'($urandom_range(4)));
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int g = 0; g < 4; g++) begin
            do_move(0, 1); do_move(3, 2); do_move(1, 1); do_move(4, 2); do_move(2, 1);
            press_new_game(2);
        end
        checks++;
        if (score_x2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_w2: got %0d want 3", score_x2);
        end
        checks++;
        if (score_x !== 4'd4) begin
            errors++;
            $display("FAIL sat_w4: got %0d want 4", score_x);
        end
    endtask

    task automatic test_reset_mid();
        do_move(0, 1); do_move(4, 2); do_move(8, 1);
        apply_reset();
        checks++;
        if ({status, win_line, move_count, lock, clear_board, score_x, score_o, draw_count} !== 28'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0",
                     {status, win_line, move_count, lock, clear_board, score_x, score_o, draw_count});
        end
        do_move(0, 1);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) b[i] = 0;
        m_sx = 0; m_so = 0; m_dr = 0;
        model_new_game();
        test_reset();
        test_x_row();
        test_over_ignore();
        test_draw();
        test_ninth_move_win();
        test_back_to_back();
        test_illegal_both();
        test_random_games();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
